partition_op_issuer: RTL and testbench

PARTITION_OP_ISSUER -- requirements
Module: partition_op_issuer

---
 rtl/partition_op_issuer.sv | 210 +++++++++++++++++++++
 tb/tb_partition_op_issuer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/partition_op_issuer.sv
// Single-outstanding instruction issuer for the partition core: decode, one-cycle start pulse, await completion, respond.
// Optional op_done watchdog enabled by defining PARTITION_ISSUER_TIMEOUT_EN.
module partition_op_issuer #(
  parameter int REGION_WIDTH   = 64,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [79:0]             in_instr,
  output logic [7:0]              op,
  output logic                    op_valid,
  output logic [REGION_WIDTH-1:0] pnew_region,
  output logic [7:0]              psplit_module_id,
  output logic [REGION_WIDTH-1:0] psplit_mask,
  output logic [7:0]              pmerge_m1,
  output logic [7:0]              pmerge_m2,
  input  logic                    op_done,
  input  logic [7:0]              core_result_id,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [7:0]              resp_opcode,
  output logic [7:0]              resp_module_id,
  output logic [1:0]              resp_status,
  output logic                    busy,
  output logic                    halted,
  output logic [15:0]             issued_count
);

  localparam logic [7:0] OP_PNEW   = 8'h00;
  localparam logic [7:0] OP_PSPLIT = 8'h01;
  localparam logic [7:0] OP_PMERGE = 8'h02;
  localparam logic [7:0] OP_MDLACC = 8'h05;
  localparam logic [7:0] OP_HALT   = 8'hFF;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_HALTED  = 2'b01;
  localparam logic [1:0] ST_ILLEGAL = 2'b10;
  localparam logic [1:0] ST_TIMEOUT = 2'b11;

  if (TIMEOUT_CYCLES < 1 || REGION_WIDTH < 8 || REGION_WIDTH > 64) begin : g_bad_params
    $error("partition_op_issuer: parameter out of range");
  end

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_HALT} state_e;

  state_e                  state_q, state_d;
  logic [7:0]              op_q, op_d;
  logic [REGION_WIDTH-1:0] pnew_region_q, pnew_region_d;
  logic [7:0]              psplit_module_id_q, psplit_module_id_d;
  logic [REGION_WIDTH-1:0] psplit_mask_q, psplit_mask_d;
  logic [7:0]              pmerge_m1_q, pmerge_m1_d;
  logic [7:0]              pmerge_m2_q, pmerge_m2_d;
  logic [7:0]              resp_opcode_q, resp_opcode_d;
  logic [7:0]              resp_module_id_q, resp_module_id_d;
  logic [1:0]              resp_status_q, resp_status_d;
  logic                    halted_q, halted_d;
  logic [15:0]             issued_count_q, issued_count_d;

  logic [7:0]  in_opcode;
  logic [7:0]  in_arg0;
  logic [63:0] in_region;

  assign in_opcode = in_instr[79:72];
  assign in_arg0   = in_instr[71:64];
  assign in_region = in_instr[63:0];

`ifdef PARTITION_ISSUER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] timer_q, timer_d;
`endif

  always_comb begin
    state_d            = state_q;
    op_d               = op_q;
    pnew_region_d      = pnew_region_q;
    psplit_module_id_d = psplit_module_id_q;
    psplit_mask_d      = psplit_mask_q;
    pmerge_m1_d        = pmerge_m1_q;
    pmerge_m2_d        = pmerge_m2_q;
    resp_opcode_d      = resp_opcode_q;
    resp_module_id_d   = resp_module_id_q;
    resp_status_d      = resp_status_q;
    halted_d           = halted_q;
    issued_count_d     = issued_count_q;
`ifdef PARTITION_ISSUER_TIMEOUT_EN
    timer_d            = timer_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (in_valid && !halted_q) begin
          op_d             = in_opcode;
          resp_opcode_d    = in_opcode;
          resp_module_id_d = 8'h00;
          case (in_opcode)
            OP_PNEW: begin
              pnew_region_d = in_region[REGION_WIDTH-1:0];
              state_d       = S_ISSUE;
            end
            OP_PSPLIT: begin
              psplit_module_id_d = in_arg0;
              psplit_mask_d      = in_region[REGION_WIDTH-1:0];
              state_d            = S_ISSUE;
            end
            OP_PMERGE: begin
              pmerge_m1_d = in_arg0;
              pmerge_m2_d = in_region[7:0];
              state_d     = S_ISSUE;
            end
            OP_MDLACC: state_d = S_ISSUE;
            OP_HALT: begin
              resp_status_d = ST_HALTED;
              halted_d      = 1'b1;
              state_d       = S_RESP;
            end
            default: begin
              resp_status_d = ST_ILLEGAL;
              state_d       = S_RESP;
            end
          endcase
        end
      end
      S_ISSUE: begin
        issued_count_d = issued_count_q + 16'd1;
        state_d        = S_WAIT;
`ifdef PARTITION_ISSUER_TIMEOUT_EN
        timer_d        = '0;
`endif
      end
      S_WAIT: begin
        if (op_done) begin
          resp_module_id_d = core_result_id;
          resp_status_d    = ST_OK;
          state_d          = S_RESP;
        end
`ifdef PARTITION_ISSUER_TIMEOUT_EN
        // The last permitted WAIT cycle has passed without completion.
        else if (timer_q == TIMER_LAST) begin
          resp_module_id_d = 8'hFF;
          resp_status_d    = ST_TIMEOUT;
          state_d          = S_RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
`endif
      end
      S_RESP: begin
        if (resp_ready) state_d = halted_q ? S_HALT : S_IDLE;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= S_IDLE;
      op_q               <= '0;
      pnew_region_q      <= '0;
      psplit_module_id_q <= '0;
      psplit_mask_q      <= '0;
      pmerge_m1_q        <= '0;
      pmerge_m2_q        <= '0;
      resp_opcode_q      <= '0;
      resp_module_id_q   <= '0;
      resp_status_q      <= '0;
      halted_q           <= 1'b0;
      issued_count_q     <= '0;
`ifdef PARTITION_ISSUER_TIMEOUT_EN
      timer_q            <= '0;
`endif
    end else begin
      state_q            <= state_d;
      op_q               <= op_d;
      pnew_region_q      <= pnew_region_d;
      psplit_module_id_q <= psplit_module_id_d;
      psplit_mask_q      <= psplit_mask_d;
      pmerge_m1_q        <= pmerge_m1_d;
      pmerge_m2_q        <= pmerge_m2_d;
      resp_opcode_q      <= resp_opcode_d;
      resp_module_id_q   <= resp_module_id_d;
      resp_status_q      <= resp_status_d;
      halted_q           <= halted_d;
      issued_count_q     <= issued_count_d;
`ifdef PARTITION_ISSUER_TIMEOUT_EN
      timer_q            <= timer_d;
`endif
    end
  end

  assign in_ready         = (state_q == S_IDLE) && !halted_q;
  assign op_valid         = (state_q == S_ISSUE);
  assign resp_valid       = (state_q == S_RESP);
  assign busy             = (state_q != S_IDLE);
  assign op               = op_q;
  assign pnew_region      = pnew_region_q;
  assign psplit_module_id = psplit_module_id_q;
  assign psplit_mask      = psplit_mask_q;
  assign pmerge_m1        = pmerge_m1_q;
  assign pmerge_m2        = pmerge_m2_q;
  assign resp_opcode      = resp_opcode_q;
  assign resp_module_id   = resp_module_id_q;
  assign resp_status      = resp_status_q;
  assign halted           = halted_q;
  assign issued_count     = issued_count_q;

endmodule

// File: tb/tb_partition_op_issuer.sv
// Directed bench for partition_op_issuer; inputs driven and outputs sampled on the falling clock edge.
module tb_partition_op_issuer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [79:0] in_instr = '0;
  logic [7:0]  op;
  logic        op_valid;
  logic [63:0] pnew_region;
  logic [7:0]  psplit_module_id;
  logic [63:0] psplit_mask;
  logic [7:0]  pmerge_m1;
  logic [7:0]  pmerge_m2;
  logic        op_done = 1'b0;
  logic [7:0]  core_result_id = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [7:0]  resp_opcode;
  logic [7:0]  resp_module_id;
  logic [1:0]  resp_status;
  logic        busy;
  logic        halted;
  logic [15:0] issued_count;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  partition_op_issuer #(.REGION_WIDTH(64), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .op(op), .op_valid(op_valid), .pnew_region(pnew_region), .psplit_module_id(psplit_module_id),
    .psplit_mask(psplit_mask), .pmerge_m1(pmerge_m1), .pmerge_m2(pmerge_m2), .op_done(op_done),
    .core_result_id(core_result_id), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_opcode(resp_opcode), .resp_module_id(resp_module_id), .resp_status(resp_status),
    .busy(busy), .halted(halted), .issued_count(issued_count)
  );

  // Offer one instruction for a single edge; returns in the cycle after the accepting edge.
  task automatic send(input logic [7:0] opc, input logic [7:0] a0, input logic [63:0] rg);
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = {opc, a0, rg};
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%0h exp=1", in_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0h exp=0", busy); end
    total++; if (op_valid !== 1'b0) begin bad++; $display("FAIL rst_op_valid got=%0h exp=0", op_valid); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid got=%0h exp=0", resp_valid); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL rst_halted got=%0h exp=0", halted); end
    total++; if (issued_count !== 16'd0) begin bad++; $display("FAIL rst_issued got=%0h exp=0", issued_count); end
    total++; if (pnew_region !== 64'd0) begin bad++; $display("FAIL rst_pnew_region got=%0h exp=0", pnew_region); end
    rst_n = 1'b1;
  endtask

  task automatic test_pnew();
    send(8'h00, 8'h00, 64'h0F);
    total++; if (op_valid !== 1'b1) begin bad++; $display("FAIL pnew_op_valid got=%0h exp=1", op_valid); end
    total++; if (op !== 8'h00) begin bad++; $display("FAIL pnew_op got=%0h exp=0", op); end
    total++; if (pnew_region !== 64'h0F) begin bad++; $display("FAIL pnew_region got=%0h exp=f", pnew_region); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL pnew_in_ready got=%0h exp=0", in_ready); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (op_valid !== 1'b0) begin bad++; $display("FAIL pnew_single_pulse c%0d got=%0h exp=0", i, op_valid); end
      total++; if (pnew_region !== 64'h0F) begin bad++; $display("FAIL pnew_hold c%0d got=%0h exp=f", i, pnew_region); end
    end
    op_done = 1'b1;
    core_result_id = 8'h00;
    @(negedge clk);
    op_done = 1'b0;
    total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL pnew_resp_valid got=%0h exp=1", resp_valid); end
    total++; if ({resp_opcode, resp_module_id, resp_status} !== {8'h00, 8'h00, 2'b00}) begin bad++;
      $display("FAIL pnew_resp got=%0h/%0h/%0h exp=0/0/0", resp_opcode, resp_module_id, resp_status); end
    total++; if (issued_count !== 16'd1) begin bad++; $display("FAIL pnew_issued got=%0d exp=1", issued_count); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL pnew_resp_in_ready got=%0h exp=0", in_ready); end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL pnew_resp_drop got=%0h exp=0", resp_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL pnew_in_ready_back got=%0h exp=1", in_ready); end
  endtask

  task automatic test_split_merge();
    send(8'h01, 8'h00, 64'h03);
    total++; if ({op_valid, op} !== {1'b1, 8'h01}) begin bad++; $display("FAIL split_op got=%0h/%0h exp=1/1", op_valid, op); end
    total++; if (psplit_module_id !== 8'h00) begin bad++; $display("FAIL split_id got=%0h exp=0", psplit_module_id); end
    total++; if (psplit_mask !== 64'h03) begin bad++; $display("FAIL split_mask got=%0h exp=3", psplit_mask); end
    @(negedge clk);
    op_done = 1'b1;
    core_result_id = 8'h11;
    @(negedge clk);
    op_done = 1'b0;
    total++; if ({resp_valid, resp_opcode, resp_module_id, resp_status} !== {1'b1, 8'h01, 8'h11, 2'b00}) begin bad++;
      $display("FAIL split_resp got=%0h/%0h/%0h/%0h exp=1/1/11/0", resp_valid, resp_opcode, resp_module_id, resp_status); end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    send(8'h02, 8'h00, 64'hA5A5_0000_0000_0001);
    total++; if ({op_valid, op} !== {1'b1, 8'h02}) begin bad++; $display("FAIL merge_op got=%0h/%0h exp=1/2", op_valid, op); end
    total++; if ({pmerge_m1, pmerge_m2} !== {8'h00, 8'h01}) begin bad++;
      $display("FAIL merge_operands got=%0h/%0h exp=0/1", pmerge_m1, pmerge_m2); end
    @(negedge clk);
    op_done = 1'b1;
    core_result_id = 8'h22;
    @(negedge clk);
    op_done = 1'b0;
    total++; if ({resp_valid, resp_opcode, resp_module_id, resp_status} !== {1'b1, 8'h02, 8'h22, 2'b00}) begin bad++;
      $display("FAIL merge_resp got=%0h/%0h/%0h/%0h exp=1/2/22/0", resp_valid, resp_opcode, resp_module_id, resp_status); end
    total++; if (issued_count !== 16'd3) begin bad++; $display("FAIL merge_issued got=%0d exp=3", issued_count); end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_illegal_stall();
    send(8'h42, 8'h5A, 64'h1234);
    total++; if (op_valid !== 1'b0) begin bad++; $display("FAIL ill_op_valid got=%0h exp=0", op_valid); end
    total++; if ({resp_valid, resp_opcode, resp_module_id, resp_status} !== {1'b1, 8'h42, 8'h00, 2'b10}) begin bad++;
      $display("FAIL ill_resp got=%0h/%0h/%0h/%0h exp=1/42/0/2", resp_valid, resp_opcode, resp_module_id, resp_status); end
    for (int i = 0; i < 5; i++) begin
      total++; if ({resp_valid, resp_module_id, resp_status, in_ready} !== {1'b1, 8'h00, 2'b10, 1'b0}) begin bad++;
        $display("FAIL stall_hold c%0d got=%0h/%0h/%0h/%0h exp=1/0/2/0", i, resp_valid, resp_module_id, resp_status, in_ready); end
      op_done = (i == 0);
      core_result_id = 8'h99;
      @(negedge clk);
    end
    op_done = 1'b0;
    total++; if (issued_count !== 16'd3) begin bad++; $display("FAIL ill_issued got=%0d exp=3", issued_count); end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ill_in_ready_back got=%0h exp=1", in_ready); end
  endtask

  task automatic test_back_to_back();
    send(8'h05, 8'h00, 64'h0);
    total++; if ({op_valid, op} !== {1'b1, 8'h05}) begin bad++; $display("FAIL mdl_op got=%0h/%0h exp=1/5", op_valid, op); end
    @(negedge clk);
    op_done = 1'b1;
    core_result_id = 8'h33;
    @(negedge clk);
    op_done = 1'b0;
    resp_ready = 1'b1;
    in_valid = 1'b1;
    in_instr = {8'h00, 8'h00, 64'h77};
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_same_cycle got=%0h exp=0", in_ready); end
    total++; if (resp_module_id !== 8'h33) begin bad++; $display("FAIL mdl_resp_id got=%0h exp=33", resp_module_id); end
    @(negedge clk);
    resp_ready = 1'b0;
    total++; if ({in_ready, resp_valid} !== {1'b1, 1'b0}) begin bad++;
      $display("FAIL b2b_ready_next got=%0h/%0h exp=1/0", in_ready, resp_valid); end
    @(negedge clk);
    in_valid = 1'b0;
    total++; if ({op_valid, pnew_region} !== {1'b1, 64'h77}) begin bad++;
      $display("FAIL b2b_issue got=%0h/%0h exp=1/77", op_valid, pnew_region); end
    total++; if (issued_count !== 16'd4) begin bad++; $display("FAIL b2b_issued got=%0d exp=4", issued_count); end
  endtask

  // Entered with the 0x77 PNEW in its op_valid cycle; the core never answers it.
  task automatic test_wait_and_reset();
`ifdef PARTITION_ISSUER_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      total++; if ({resp_valid, busy} !== 2'b01) begin bad++; $display("FAIL to_wait c%0d got=%0h/%0h exp=0/1", i, resp_valid, busy); end
    end
    @(negedge clk);
    total++; if ({resp_valid, resp_module_id, resp_status} !== {1'b1, 8'hFF, 2'b11}) begin bad++;
      $display("FAIL to_resp got=%0h/%0h/%0h exp=1/ff/3", resp_valid, resp_module_id, resp_status); end
    op_done = 1'b1;
    core_result_id = 8'h44;
    @(negedge clk);
    op_done = 1'b0;
    total++; if ({resp_module_id, resp_status} !== {8'hFF, 2'b11}) begin bad++;
      $display("FAIL to_late_done got=%0h/%0h exp=ff/3", resp_module_id, resp_status); end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    send(8'h00, 8'h00, 64'h88);
    repeat (3) @(negedge clk);
    total++; if (issued_count !== 16'd6) begin bad++; $display("FAIL to_issued got=%0d exp=6", issued_count); end
`else
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++; if ({busy, resp_valid, op_valid} !== 3'b100) begin bad++;
        $display("FAIL hang_wait c%0d got=%0h/%0h/%0h exp=1/0/0", i, busy, resp_valid, op_valid); end
    end
    total++; if (issued_count !== 16'd5) begin bad++; $display("FAIL hang_issued got=%0d exp=5", issued_count); end
`endif
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if ({busy, in_ready, op_valid, resp_valid, halted} !== 5'b01000) begin bad++;
      $display("FAIL midrst_ctrl got=%0h/%0h/%0h/%0h/%0h exp=0/1/0/0/0", busy, in_ready, op_valid, resp_valid, halted); end
    total++; if (issued_count !== 16'd0) begin bad++; $display("FAIL midrst_issued got=%0d exp=0", issued_count); end
    total++; if ({pnew_region, op, resp_opcode, resp_module_id, resp_status} !== 90'd0) begin bad++;
      $display("FAIL midrst_data got=%0h/%0h/%0h/%0h/%0h exp=0", pnew_region, op, resp_opcode, resp_module_id, resp_status); end
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1;
    in_instr = {8'h00, 8'h00, 64'h3C};
    @(negedge clk);
    in_valid = 1'b0;
    total++; if ({op_valid, pnew_region, issued_count} !== {1'b1, 64'h3C, 16'd0}) begin bad++;
      $display("FAIL post_rst_accept got=%0h/%0h/%0h exp=1/3c/0", op_valid, pnew_region, issued_count); end
    @(negedge clk);
    op_done = 1'b1;
    core_result_id = 8'h55;
    @(negedge clk);
    op_done = 1'b0;
    total++; if ({resp_valid, resp_module_id, issued_count} !== {1'b1, 8'h55, 16'd1}) begin bad++;
      $display("FAIL post_rst_resp got=%0h/%0h/%0h exp=1/55/1", resp_valid, resp_module_id, issued_count); end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_halt();
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = {8'hFF, 8'h00, 64'h0};
    @(negedge clk);
    in_instr = {8'h00, 8'h00, 64'h5};
    total++; if ({resp_valid, resp_opcode, resp_module_id, resp_status} !== {1'b1, 8'hFF, 8'h00, 2'b01}) begin bad++;
      $display("FAIL halt_resp got=%0h/%0h/%0h/%0h exp=1/ff/0/1", resp_valid, resp_opcode, resp_module_id, resp_status); end
    total++; if ({halted, in_ready, op_valid} !== 3'b100) begin bad++;
      $display("FAIL halt_flags got=%0h/%0h/%0h exp=1/0/0", halted, in_ready, op_valid); end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++; if ({in_ready, op_valid, busy, halted, resp_valid} !== 5'b00110) begin bad++;
        $display("FAIL halt_absorb c%0d got=%0h/%0h/%0h/%0h/%0h exp=0/0/1/1/0", i, in_ready, op_valid, busy, halted, resp_valid); end
      @(negedge clk);
    end
    in_valid = 1'b0;
    total++; if (issued_count !== 16'd1) begin bad++; $display("FAIL halt_issued got=%0d exp=1", issued_count); end
  endtask

  initial begin
    test_reset();
    test_pnew();
    test_split_merge();
    test_illegal_stall();
    test_back_to_back();
    test_wait_and_reset();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
